if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised instruction fetch queue between the instruction-bus response and the IF/ID boundary; supersedes the single-entry IF pipeline register.
- Buffers up to DEPTH fetched packets of {PC, instruction, exception vector}.
- Decouples fetch from decode stalls and decodes the TLB exception code into the pipeline exception vector at enqueue.
- Flush empties the queue in one cycle.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- PC_W, 32, PC width.
- INSTR_W, 32, instruction width.
- EXC_W, 19, pipeline exception vector width.
- AFULL_LVL, DEPTH-1, occupancy at or above which almost_full asserts.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (branch mispredict / exception redirect).
- in_valid  in  1  fetch packet offered.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- in_pc  in  PC_W  PC of packet.
- in_instr  in  INSTR_W  instruction word from cpu_ibus rdata.
- in_tlb_except  in  2  00 none, 01 TLB refill, 10 TLB invalid, 11 reserved (treated as none).
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode accepts head (inverse of decode stall).
- out_pc  out  PC_W  head PC.
- out_instr  out  INSTR_W  head instruction.
- out_except  out  EXC_W  head exception vector.
- count  out  $clog2(DEPTH)+1  current occupancy.
- almost_full  out  1  count >= AFULL_LVL; fetch throttle hint.

Behaviour:
- Storage: DEPTH-entry circular buffer; rd_ptr and wr_ptr are log2(DEPTH) bits and wrap naturally modulo DEPTH; count is tracked separately, so full and empty are unambiguous.
- Push: fires when in_valid && in_ready && !flush. Writes the entry at wr_ptr; wr_ptr increments.
- Pop: fires when out_valid && out_ready && !flush. rd_ptr increments.
- count update on each edge:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on push and pop together.
- Simultaneous push and pop while full: impossible, because in_ready is already low; the pop proceeds and in_ready rises the next cycle.
- Simultaneous push and pop while count==1: legal; the head advances to the new entry.
- Exception decode at enqueue, stored per entry:
  - code 01 sets exception bit 8 only;
  - code 10 sets exception bit 7 only;
  - any other code stores all zeros.
- Instruction field of an excepting entry: when the stored exception vector is nonzero, 0x00000000 (NOP) is stored in place of in_instr, so decode sees no side-effecting op.
- Outputs are driven from the entry at rd_ptr:
  - out_valid = (count != 0);
  - when empty, out_pc, out_instr and out_except are 0.
- Latency: a packet pushed in cycle N is visible on the outputs in cycle N+1 (no bypass; see Optional Feature).
- flush: highest priority after rst. On the edge it zeroes count, rd_ptr and wr_ptr; a push or pop in the same cycle is discarded. in_ready is 1 and out_valid is 0 the following cycle.
- rst: same clearing as flush. Storage contents need not be cleared.
- Reset values: in_ready=1, out_valid=0, out_pc=0, out_instr=0, out_except=0, count=0, almost_full=(AFULL_LVL==0).
- Reset or flush mid-stall (out_ready low, queue full): the queue empties regardless of out_ready.
- in_* values are ignored when in_valid is low. out_ready is ignored when the queue is empty.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined: when count==0, in_valid is high and flush is low, the outputs present the incoming packet combinationally (out_valid=1, decoded exception, NOP substitution applied).
  - If out_ready is also high, the packet is consumed directly: not written, pointers and count unchanged.
  - Otherwise it is enqueued normally.
  - Zero-cycle latency when empty.
- Not defined: outputs are registered-path only and latency is one cycle, as above.

Test Plan:
- Reset, then push PC 0xBFC00000 / instr 0x24020001 with code 00, out_ready=1 → next cycle out_valid=1, out_pc=0xBFC00000, out_instr=0x24020001, out_except=0, count=1; popped the cycle after, count=0.
- out_ready=0, push 4 packets PC 0x100,0x104,0x108,0x10C → count=4, in_ready=0, almost_full=1; a 5th push is refused. With out_ready=1, the outputs pop in order 0x100..0x10C.
- Push with code 01 at PC 0x2000 → out_except has only bit 8 set and out_instr=0. Code 10 → only bit 7 set. Code 11 → out_except=0 and the instruction is preserved.
- Queue at count=3, assert flush together with in_valid and out_ready → next cycle count=0, out_valid=0, in_ready=1; the flushed-cycle packet never appears.
- Wrap-around: 10 push/pop pairs at count=1 steady state → the PC sequence is preserved in order, count stays 1, and the pointers wrap past DEPTH-1.
- With IFQ_BYPASS_EN, empty queue, in_valid=1 and out_ready=1 on PC 0x300 → out_valid=1 and out_pc=0x300 in the same cycle, with count remaining 0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular buffer of {PC, instr, exception} between ibus and IF/ID.
// Optional macro IFQ_BYPASS_EN: an empty queue forwards the incoming packet combinationally.
module if_fetch_queue #(
  parameter int DEPTH     = 4,
  parameter int PC_W      = 32,
  parameter int INSTR_W   = 32,
  parameter int EXC_W     = 19,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic [1:0]               in_tlb_except,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [EXC_W-1:0]         out_except,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);
  // Handshake: a transfer happens on an edge where valid && ready are both high and flush is low.

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [EXC_W-1:0]   exc_mem_q   [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [EXC_W-1:0]   in_exc;
  logic [INSTR_W-1:0] in_instr_eff;
  logic               empty;
  logic               bypass_act;
  logic               push;
  logic               pop;

  // Exception vector is decoded once at enqueue; excepting packets carry a NOP.
  always_comb begin
    in_exc = '0;
    case (in_tlb_except)
      2'b01:   in_exc[8] = 1'b1;
      2'b10:   in_exc[7] = 1'b1;
      default: ;
    endcase
    in_instr_eff = (in_exc != '0) ? '0 : in_instr;
  end

  assign empty    = (count_q == '0);
  assign in_ready = (count_q < CNT_W'(DEPTH));

`ifdef IFQ_BYPASS_EN
  assign bypass_act = empty && in_valid && !flush;
`else
  assign bypass_act = 1'b0;
`endif

  // A bypassed packet taken by decode the same cycle never touches storage.
  assign push = in_valid && in_ready && !flush && !(bypass_act && out_ready);
  assign pop  = !empty && out_ready && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      instr_mem_q[wr_ptr_q] <= in_instr_eff;
      exc_mem_q[wr_ptr_q]   <= in_exc;
    end
  end

  always_comb begin
    out_pc     = '0;
    out_instr  = '0;
    out_except = '0;
    if (bypass_act) begin
      out_pc     = in_pc;
      out_instr  = in_instr_eff;
      out_except = in_exc;
    end else if (!empty) begin
      out_pc     = pc_mem_q[rd_ptr_q];
      out_instr  = instr_mem_q[rd_ptr_q];
      out_except = exc_mem_q[rd_ptr_q];
    end
  end

  assign out_valid   = !empty || bypass_act;
  assign count       = count_q;
  assign almost_full = (count_q >= CNT_W'(AFULL_LVL));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: reset checks, exception-decode vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_if_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, almost_full;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
  logic [1:0]  in_tlb_except;
  logic [18:0] out_except;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [18:0] exc;
  } ent_t;
  ent_t exp_q[$];

  typedef struct packed {
    logic [1:0]  tlb;
    logic [31:0] instr;
    logic [18:0] exp_exc;
    logic [31:0] exp_instr;
  } vec_t;
  vec_t vecs[4];

  if_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_tlb_except(in_tlb_except),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_except(out_except), .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_pc = '0; in_instr = '0; in_tlb_except = '0;
  endtask

  // One clock cycle: drive, compare against the model just before the edge, advance the model.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [1:0] tlb, input logic ordy, input logic fl);
    ent_t inc, hd;
    logic byp, exp_v, do_push, do_pop;
    int   sz;
    in_valid = v; in_pc = pc; in_instr = ins; in_tlb_except = tlb;
    out_ready = ordy; flush = fl;
    #2;
    sz = exp_q.size();
    inc.pc    = pc;
    inc.exc   = (tlb == 2'd1) ? 19'd256 : (tlb == 2'd2) ? 19'd128 : 19'd0;
    inc.instr = (inc.exc != 0) ? 32'd0 : ins;
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = (sz == 0) && v && !fl;
`endif
    if (byp)          hd = inc;
    else if (sz != 0) hd = exp_q[0];
    else              hd = '0;
    exp_v = byp || (sz != 0);
    check("out_valid",   64'(out_valid),   64'(exp_v));
    check("count",       64'(count),       64'(sz));
    check("in_ready",    64'(in_ready),    64'(sz < DEPTH));
    check("almost_full", 64'(almost_full), 64'(sz >= DEPTH - 1));
    check("out_pc",      64'(out_pc),      64'(hd.pc));
    check("out_instr",   64'(out_instr),   64'(hd.instr));
    check("out_except",  64'(out_except),  64'(hd.exc));
    do_push = v && (sz < DEPTH) && !fl && !(byp && ordy);
    do_pop  = (sz != 0) && ordy && !fl;
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(inc);
    end
    #1;
    idle_inputs();
    #1;
  endtask

  initial begin
    vecs[0] = '{tlb: 2'b01, instr: 32'h12345678, exp_exc: 19'h00100, exp_instr: 32'h0};
    vecs[1] = '{tlb: 2'b10, instr: 32'hDEADBEEF, exp_exc: 19'h00080, exp_instr: 32'h0};
    vecs[2] = '{tlb: 2'b11, instr: 32'h24020001, exp_exc: 19'h00000, exp_instr: 32'h24020001};
    vecs[3] = '{tlb: 2'b00, instr: 32'h8C220004, exp_exc: 19'h00000, exp_instr: 32'h8C220004};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_in_ready",    64'(in_ready),    64'd1);
    check("rst_out_valid",   64'(out_valid),   64'd0);
    check("rst_count",       64'(count),       64'd0);
    check("rst_almost_full", 64'(almost_full), 64'd0);
    check("rst_out_pc",      64'(out_pc),      64'd0);
    check("rst_out_except",  64'(out_except),  64'd0);

`ifndef IFQ_BYPASS_EN
    // Single packet: visible one cycle after push, popped the cycle after.
    cycle(1'b1, 32'hBFC00000, 32'h24020001, 2'b00, 1'b1, 1'b0);
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_pc",    64'(out_pc),    64'hBFC00000);
    check("first_instr", 64'(out_instr), 64'h24020001);
    check("first_exc",   64'(out_except), 64'd0);
    check("first_count", 64'(count),     64'd1);
    cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    check("first_popped", 64'(count), 64'd0);
`else
    cycle(1'b1, 32'h300, 32'h24020001, 2'b00, 1'b1, 1'b0);
    in_valid = 1'b1; in_pc = 32'h300; out_ready = 1'b1;
    #1;
    check("byp_valid", 64'(out_valid), 64'd1);
    check("byp_pc",    64'(out_pc),    64'h300);
    @(posedge clk);
    #1 idle_inputs();
    #1 check("byp_count", 64'(count), 64'd0);
`endif

    // Fill under stall, refuse the fifth, drain in order.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 2'b00, 1'b0, 1'b0);
    check("full_count", 64'(count),       64'd4);
    check("full_ready", 64'(in_ready),    64'd0);
    check("full_afull", 64'(almost_full), 64'd1);
    cycle(1'b1, 32'h110, 32'hA4, 2'b00, 1'b0, 1'b0);
    check("refused_count", 64'(count),  64'd4);
    check("refused_head",  64'(out_pc), 64'h100);
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 64'(out_pc), 64'h100 + 64'(4 * i));
      cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    end
    check("drained_count", 64'(count), 64'd0);

    // Exception decode table.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'h2000, vecs[i].instr, vecs[i].tlb, 1'b0, 1'b0);
      check("vec_pc",    64'(out_pc),     64'h2000);
      check("vec_exc",   64'(out_except), 64'(vecs[i].exp_exc));
      check("vec_instr", 64'(out_instr),  64'(vecs[i].exp_instr));
      cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
    end

    // Flush at count 3 with push and pop offered in the same cycle.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h400 + 32'(4 * i), 32'hB0, 2'b00, 1'b0, 1'b0);
    check("pre_flush_count", 64'(count), 64'd3);
    cycle(1'b1, 32'h500, 32'hB5, 2'b00, 1'b1, 1'b1);
    check("flush_count", 64'(count),     64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready),  64'd1);
    cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    check("flush_no_ghost", 64'(out_valid), 64'd0);

    // Steady state at count 1 so both pointers wrap.
    cycle(1'b1, 32'h600, 32'hC0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("wrap_pc", 64'(out_pc), 64'h600 + 64'(4 * i));
      cycle(1'b1, 32'h604 + 32'(4 * i), 32'hC1 + 32'(i), 2'b00, 1'b1, 1'b0);
      check("wrap_count", 64'(count), 64'd1);
    end
    cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
